// File: rtl/lane_dispatch.sv
// lane_dispatch: index-steered dispatcher feeding N_LANES one-entry output
// registers. Each input word carries a lane index. The word is loaded into
// that lane's register and held until the lane's consumer takes it.
// Out-of-range indices are accepted and discarded. They set a sticky
// error flag and bump a saturating drop counter.
//
// Optional feature: define LANE_DISPATCH_SKID_EN to insert a 2-entry input
// FIFO. in_ready then comes from a register, and accept-to-lane latency is
// 2 cycles. Without it, in_ready is combinational and latency is 1 cycle.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_data, in_sel      input word and destination lane index
//   lane_valid[N]        per-lane word present (registered)
//   lane_ready[N]        per-lane consumer accepts
//   lane_data[N*WIDTH]   per-lane word, lane i at [i*WIDTH +: WIDTH]
//   err_oob              sticky out-of-range index seen
//   drop_cnt[8]          saturating count of dropped out-of-range words
module lane_dispatch #(
    parameter int N_LANES = 2,
    parameter int WIDTH   = 8,
    parameter int SEL_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_LANES-1:0]       lane_valid,
    input  logic [N_LANES-1:0]       lane_ready,
    output logic [N_LANES*WIDTH-1:0] lane_data,
    output logic                     err_oob,
    output logic [7:0]               drop_cnt
);

    localparam logic [SEL_W:0] LANES_EXT = (SEL_W+1)'(N_LANES);

    // Dispatch-side view: either the input port directly or the FIFO head.
    logic             d_valid;
    logic [SEL_W-1:0] d_sel;
    logic [WIDTH-1:0] d_data;
    logic             sel_oob;
    logic             lane_free;
    logic             d_fire;

`ifdef LANE_DISPATCH_SKID_EN
    logic [WIDTH-1:0] fifo_data [2];
    logic [SEL_W-1:0] fifo_sel  [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             in_ready_r;
    logic             push;

    assign push     = in_valid && in_ready;
    assign in_ready = in_ready_r && !rst;
    assign d_valid  = (count != 2'd0);
    assign d_sel    = fifo_sel[rd_ptr];
    assign d_data   = fifo_data[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !d_fire)
            count_next = count + 2'd1;
        else if (!push && d_fire)
            count_next = count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_r <= 1'b0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= in_data;
                fifo_sel[wr_ptr]  <= in_sel;
                wr_ptr            <= ~wr_ptr;
            end
            if (d_fire)
                rd_ptr <= ~rd_ptr;
            count      <= count_next;
            // Registered "not full" computed from next occupancy.
            in_ready_r <= (count_next != 2'd2);
        end
    end
`else
    assign d_valid  = in_valid;
    assign d_sel    = in_sel;
    assign d_data   = in_data;
    assign in_ready = !rst && lane_free;
`endif

    // A target lane can take a word if it is empty or draining this cycle.
    // Out-of-range words are always taken, because they are discarded.
    always_comb begin
        sel_oob   = ({1'b0, d_sel} >= LANES_EXT);
        lane_free = sel_oob;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (!sel_oob && d_sel == i[SEL_W-1:0])
                lane_free = !lane_valid[i] || lane_ready[i];
        end
    end

    assign d_fire = d_valid && lane_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_valid <= '0;
            lane_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                // Load wins over transfer, which gives pass-through refill.
                if (d_fire && !sel_oob && d_sel == i[SEL_W-1:0]) begin
                    lane_valid[i]                 <= 1'b1;
                    lane_data[i*WIDTH +: WIDTH]   <= d_data;
                end else if (lane_valid[i] && lane_ready[i]) begin
                    lane_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob  <= 1'b0;
            drop_cnt <= '0;
        end else if (d_fire && sel_oob) begin
            err_oob <= 1'b1;
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_lane_dispatch.sv
module tb_lane_dispatch;

    logic        clk = 1'b0;
    logic        rst;

    // Two-lane instance
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [0:0]  in_sel;
    logic [1:0]  lane_valid;
    logic [1:0]  lane_ready;
    logic [15:0] lane_data;
    logic        err_oob;
    logic [7:0]  drop_cnt;

    // Three-lane instance (index 3 is out of range)
    logic        in3_valid;
    logic        in3_ready;
    logic [7:0]  in3_data;
    logic [1:0]  in3_sel;
    logic [2:0]  lane3_valid;
    logic [2:0]  lane3_ready;
    logic [23:0] lane3_data;
    logic        err3_oob;
    logic [7:0]  drop3_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lane_dispatch #(.N_LANES(2), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .lane_valid(lane_valid), .lane_ready(lane_ready),
        .lane_data(lane_data),
        .err_oob(err_oob), .drop_cnt(drop_cnt)
    );

    lane_dispatch #(.N_LANES(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in3_valid), .in_ready(in3_ready),
        .in_data(in3_data), .in_sel(in3_sel),
        .lane_valid(lane3_valid), .lane_ready(lane3_ready),
        .lane_data(lane3_data),
        .err_oob(err3_oob), .drop_cnt(drop3_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; lane_ready = '0;
        in3_valid = 1'b0; in3_data = '0; in3_sel = '0; lane3_ready = '0;

        // Reset then idle
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("idle_lane_valid", 32'(lane_valid), 32'd0);
        check("idle_err", 32'(err_oob), 32'd0);
        check("idle_drop", 32'(drop_cnt), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Basic steer
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 1'b1;
        #1;
        check("steer_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("steer_valid", 32'(lane_valid), 32'h2);
        check("steer_data", 32'(lane_data[15:8]), 32'hA5);
        #1;
        check("steer_busy_ready", 32'(in_ready), 32'd0);
        step();
        check("steer_hold", 32'(lane_valid), 32'h2);
        lane_ready = 2'b10;
        #1;
        check("steer_drain_ready", 32'(in_ready), 32'd1);
        step();
        check("steer_cleared", 32'(lane_valid), 32'h0);
        lane_ready = 2'b00;

        // Back-pressure isolation
        in_valid = 1'b1; in_data = 8'h77; in_sel = 1'b0;
        step();
        in_data = 8'h99;
        #1;
        check("bp_lane0_held", 32'(lane_valid), 32'h1);
        check("bp_in_ready_blocked", 32'(in_ready), 32'd0);
        step();
        check("bp_lane0_unchanged", 32'(lane_data[7:0]), 32'h77);
        in_data = 8'h3C; in_sel = 1'b1;
        #1;
        check("bp_lane1_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_both_valid", 32'(lane_valid), 32'h3);
        check("bp_lane1_data", 32'(lane_data[15:8]), 32'h3C);
        check("bp_lane0_data", 32'(lane_data[7:0]), 32'h77);
        lane_ready = 2'b11;
        step();
        check("bp_drained", 32'(lane_valid), 32'h0);

        // Pass-through refill on lane 0
        lane_ready = 2'b01;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01;
        step();
        check("pt_w1_valid", 32'(lane_valid), 32'h1);
        check("pt_w1_data", 32'(lane_data[7:0]), 32'h01);
        in_data = 8'h02;
        #1;
        check("pt_refill_ready", 32'(in_ready), 32'd1);
        step();
        check("pt_w2_valid", 32'(lane_valid), 32'h1);
        check("pt_w2_data", 32'(lane_data[7:0]), 32'h02);
        in_data = 8'h03;
        step();
        check("pt_w3_valid", 32'(lane_valid), 32'h1);
        check("pt_w3_data", 32'(lane_data[7:0]), 32'h03);
        in_valid = 1'b0;
        step();
        check("pt_empty", 32'(lane_valid), 32'h0);

        // Reset mid-stream
        lane_ready = 2'b00;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        step();
        in_sel = 1'b1; in_data = 8'h22;
        step();
        in_valid = 1'b0;
        check("mid_both_valid", 32'(lane_valid), 32'h3);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_valid", 32'(lane_valid), 32'h0);
        check("mid_rst_data", 32'(lane_data), 32'h0);
        rst = 1'b0;
        step();
        step();
        check("mid_no_reappear", 32'(lane_valid), 32'h0);

        // Out-of-range on the three-lane instance
        in3_valid = 1'b1; in3_sel = 2'd3; in3_data = 8'h5A;
        #1;
        check("oob_in_ready", 32'(in3_ready), 32'd1);
        step();
        check("oob_err_first", 32'(err3_oob), 32'd1);
        check("oob_drop_first", 32'(drop3_cnt), 32'd1);
        for (int i = 1; i < 300; i++) begin
            in3_data = 8'(i);
            step();
            if (i == 254)
                check("oob_drop_255", 32'(drop3_cnt), 32'd255);
        end
        in3_valid = 1'b0;
        check("oob_no_lane", 32'(lane3_valid), 32'h0);
        check("oob_drop_sat", 32'(drop3_cnt), 32'd255);
        check("oob_err_sticky", 32'(err3_oob), 32'd1);

        // Highest in-range index on the three-lane instance
        in3_valid = 1'b1; in3_sel = 2'd2; in3_data = 8'hC3;
        step();
        in3_valid = 1'b0;
        check("lane2_valid", 32'(lane3_valid), 32'h4);
        check("lane2_data", 32'(lane3_data[23:16]), 32'hC3);
        check("lane2_drop_unchanged", 32'(drop3_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
